// File: rtl/rotator_pkg.sv
// ============================================================================
// Module  : rotator_pkg
// Brief   : Shared widths and FSM state type for the rotate step controller.
// Rev     : 1.0  initial release
// ============================================================================
`default_nettype none

package rotator_pkg;

  localparam int DATA_W = 8;
  localparam int AMT_W  = 3;
  localparam int CNT_W  = 4;

  typedef enum logic [0:0] {
    RSC_IDLE = 1'b0,
    RSC_RUN  = 1'b1
  } rsc_state_t;

endpackage

`default_nettype wire

// File: rtl/rotate_step_ctrl_if.sv
// ============================================================================
// Module  : rotate_step_ctrl_if
// Brief   : Command and result handshake bundle for rotate_step_ctrl.
// Rev     : 1.0  initial release
// ============================================================================
`default_nettype none

interface rotate_step_ctrl_if;
  import rotator_pkg::*;

  logic              cmd_valid;
  logic              cmd_ready;
  logic [DATA_W-1:0] cmd_data;
  logic [AMT_W-1:0]  cmd_amount;
  logic [CNT_W-1:0]  cmd_count;
  logic              out_valid;
  logic              out_ready;
  logic [DATA_W-1:0] d_out;
  logic              out_last;
  logic              busy;

  // master issues commands and consumes results; slave is the controller
  modport master (
    output cmd_valid, cmd_data, cmd_amount, cmd_count, out_ready,
    input  cmd_ready, out_valid, d_out, out_last, busy
  );

  modport slave (
    input  cmd_valid, cmd_data, cmd_amount, cmd_count, out_ready,
    output cmd_ready, out_valid, d_out, out_last, busy
  );

endinterface

`default_nettype wire

// File: rtl/right_rotator.sv
// ============================================================================
// Module  : right_rotator
// Brief   : Combinational 8-bit rotate-right by a 3-bit amount.
// Rev     : 1.0  initial release
// ============================================================================
`default_nettype none

module right_rotator
  import rotator_pkg::*;
(
  input  wire logic [DATA_W-1:0] d_in,
  input  wire logic [AMT_W-1:0]  bit_amount,
  output logic      [DATA_W-1:0] rot_out
);

  localparam logic [AMT_W:0] c_width = (AMT_W+1)'(DATA_W);

  // a left shift by the full width yields zero, so amount 0 passes d_in through
  assign rot_out = (d_in >> bit_amount) | (d_in << (c_width - {1'b0, bit_amount}));

endmodule

`default_nettype wire

// File: rtl/rotate_step_ctrl.sv
// ============================================================================
// Module  : rotate_step_ctrl
// Brief   : Accepts rotate commands and streams each intermediate rotation.
// Rev     : 1.0  initial release
// ============================================================================
`default_nettype none

module rotate_step_ctrl
  import rotator_pkg::*;
(
  input  wire logic          clk,
  input  wire logic          rst,
  rotate_step_ctrl_if.slave  bus
);

  rsc_state_t        r_state;
  rsc_state_t        w_state_next;
  logic [DATA_W-1:0] r_d_out;
  logic              r_out_valid;
  logic [AMT_W-1:0]  r_amt_q;
  logic [CNT_W-1:0]  r_remaining;

  logic [DATA_W-1:0] w_d_in;
  logic [AMT_W-1:0]  w_bit_amount;
  logic [DATA_W-1:0] w_rot;
  logic              w_cmd_ready;
  logic              w_busy;
  logic              w_accept;
  logic              w_handshake;
  logic              w_final;

  right_rotator u_rot (
    .d_in       (w_d_in),
    .bit_amount (w_bit_amount),
    .rot_out    (w_rot)
  );

  assign w_accept    = (r_state == RSC_IDLE) && bus.cmd_valid;
  assign w_handshake = (r_state == RSC_RUN) && r_out_valid && bus.out_ready;
  assign w_final     = (r_remaining == CNT_W'(1));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= RSC_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      RSC_IDLE: if (w_accept && (bus.cmd_count != '0)) w_state_next = RSC_RUN;
      RSC_RUN:  if (w_handshake && w_final)            w_state_next = RSC_IDLE;
      default:                                         w_state_next = RSC_IDLE;
    endcase
  end

  always_comb begin
    w_cmd_ready  = 1'b0;
    w_busy       = 1'b0;
    w_d_in       = bus.cmd_data;
    w_bit_amount = bus.cmd_amount;
    case (r_state)
      RSC_IDLE: w_cmd_ready = 1'b1;
      RSC_RUN: begin
        w_busy       = 1'b1;
        w_d_in       = r_d_out;
        w_bit_amount = r_amt_q;
      end
      default: w_cmd_ready = 1'b0;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_d_out     <= '0;
      r_out_valid <= 1'b0;
      r_amt_q     <= '0;
      r_remaining <= '0;
    end else if (w_accept) begin
      r_amt_q     <= bus.cmd_amount;
      r_remaining <= bus.cmd_count;
      // a zero-count command is consumed silently and leaves the output as is
      if (bus.cmd_count != '0) begin
        r_d_out     <= w_rot;
        r_out_valid <= 1'b1;
      end
    end else if (w_handshake) begin
      if (w_final) begin
        r_out_valid <= 1'b0;
      end else begin
        r_d_out     <= w_rot;
        r_remaining <= r_remaining - CNT_W'(1);
      end
    end
  end

  assign bus.cmd_ready = w_cmd_ready;
  assign bus.busy      = w_busy;
  assign bus.out_valid = r_out_valid;
  assign bus.d_out     = r_d_out;
  assign bus.out_last  = r_out_valid && w_final;

endmodule

`default_nettype wire

// File: tb/tb_rotate_step_ctrl.sv
// ============================================================================
// Module  : tb_rotate_step_ctrl
// Brief   : Directed self-checking bench for rotate_step_ctrl.
// Rev     : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_rotate_step_ctrl;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   vectors     = 0;
  int   miscompares = 0;

  rotate_step_ctrl_if bus ();

  rotate_step_ctrl dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=0x%02h expected=0x%02h", tag, obs, exp);
    end
  endtask

  task automatic chk_out(input string tag, input logic [7:0] d, input logic v, input logic last);
    chk({tag, "_d"},    bus.d_out,    d);
    chk({tag, "_v"},    {7'd0, bus.out_valid}, {7'd0, v});
    chk({tag, "_last"}, {7'd0, bus.out_last},  {7'd0, last});
  endtask

  task automatic send(input logic [7:0] d, input logic [2:0] a, input logic [3:0] c);
    bus.cmd_valid  = 1'b1;
    bus.cmd_data   = d;
    bus.cmd_amount = a;
    bus.cmd_count  = c;
  endtask

  initial begin
    logic [7:0] wrap_exp [8];
    wrap_exp = '{8'h80, 8'h40, 8'h20, 8'h10, 8'h08, 8'h04, 8'h02, 8'h01};

    bus.cmd_valid  = 1'b0;
    bus.cmd_data   = 8'h00;
    bus.cmd_amount = 3'd0;
    bus.cmd_count  = 4'd0;
    bus.out_ready  = 1'b1;

    // reset state
    tick();
    tick();
    chk_out("rst", 8'h00, 1'b0, 1'b0);
    chk("rst_ready", {7'd0, bus.cmd_ready}, 8'h01);
    chk("rst_busy",  {7'd0, bus.busy},      8'h00);
    #2 rst = 1'b0;
    tick();

    // single step
    send(8'h81, 3'd1, 4'd1);
    tick();
    bus.cmd_valid = 1'b0;
    chk_out("single", 8'hC0, 1'b1, 1'b1);
    chk("single_ready", {7'd0, bus.cmd_ready}, 8'h00);
    chk("single_busy",  {7'd0, bus.busy},      8'h01);
    tick();
    chk_out("single_done", 8'hC0, 1'b0, 1'b0);
    chk("single_ready2", {7'd0, bus.cmd_ready}, 8'h01);

    // full wrap
    send(8'h01, 3'd1, 4'd8);
    tick();
    bus.cmd_valid = 1'b0;
    for (int i = 0; i < 8; i++) begin
      chk_out($sformatf("wrap%0d", i), wrap_exp[i], 1'b1, (i == 7));
      tick();
    end
    chk("wrap_done_v", {7'd0, bus.out_valid}, 8'h00);

    // backpressure
    bus.out_ready = 1'b0;
    send(8'hB4, 3'd3, 4'd2);
    tick();
    bus.cmd_valid = 1'b0;
    for (int i = 0; i < 3; i++) begin
      chk_out($sformatf("stall%0d", i), 8'h96, 1'b1, 1'b0);
      tick();
    end
    chk_out("stall_end", 8'h96, 1'b1, 1'b0);
    bus.out_ready = 1'b1;
    tick();
    chk_out("bp_second", 8'hD2, 1'b1, 1'b1);
    tick();
    chk("bp_done_v", {7'd0, bus.out_valid}, 8'h00);

    // zero amount
    send(8'hA5, 3'd0, 4'd3);
    tick();
    bus.cmd_valid = 1'b0;
    for (int i = 0; i < 3; i++) begin
      chk_out($sformatf("amt0_%0d", i), 8'hA5, 1'b1, (i == 2));
      tick();
    end
    chk("amt0_done_v", {7'd0, bus.out_valid}, 8'h00);

    // zero count
    send(8'h3C, 3'd2, 4'd0);
    tick();
    bus.cmd_valid = 1'b0;
    chk("cnt0_v",     {7'd0, bus.out_valid}, 8'h00);
    chk("cnt0_ready", {7'd0, bus.cmd_ready}, 8'h01);
    chk("cnt0_busy",  {7'd0, bus.busy},      8'h00);
    tick();
    chk("cnt0_v2", {7'd0, bus.out_valid}, 8'h00);

    // no overlap: a second command held valid during RUN waits for IDLE
    send(8'h3C, 3'd2, 4'd3);
    tick();
    send(8'hFF, 3'd1, 4'd1);
    chk_out("ovl0", 8'h0F, 1'b1, 1'b0);
    chk("ovl0_ready", {7'd0, bus.cmd_ready}, 8'h00);
    tick();
    chk_out("ovl1", 8'hC3, 1'b1, 1'b0);
    chk("ovl1_ready", {7'd0, bus.cmd_ready}, 8'h00);
    tick();
    chk_out("ovl2", 8'hF0, 1'b1, 1'b1);
    tick();
    chk("ovl_gap_v",     {7'd0, bus.out_valid}, 8'h00);
    chk("ovl_gap_ready", {7'd0, bus.cmd_ready}, 8'h01);
    tick();
    bus.cmd_valid = 1'b0;
    chk_out("ovl_next", 8'hFF, 1'b1, 1'b1);
    tick();
    chk("ovl_next_done", {7'd0, bus.out_valid}, 8'h00);

    // reset mid-command
    send(8'h0F, 3'd4, 4'd5);
    tick();
    bus.cmd_valid = 1'b0;
    chk_out("mid0", 8'hF0, 1'b1, 1'b0);
    tick();
    chk_out("mid1", 8'h0F, 1'b1, 1'b0);
    #2 rst = 1'b1;
    #1;
    chk_out("mid_rst", 8'h00, 1'b0, 1'b0);
    chk("mid_rst_ready", {7'd0, bus.cmd_ready}, 8'h01);
    tick();
    #2 rst = 1'b0;
    tick();
    chk("post_rst_ready", {7'd0, bus.cmd_ready}, 8'h01);
    for (int i = 0; i < 4; i++) begin
      chk_out($sformatf("post_rst%0d", i), 8'h00, 1'b0, 1'b0);
      tick();
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/rotate_step_ctrl.md
# rotate_step_ctrl

Sequential command front-end for the 8-bit right rotator. Accepts a rotate command (operand, amount, repeat count) over a valid/ready handshake, then drives the combinational right-rotator stage repeatedly. It emits each intermediate rotated value as a registered result stream with backpressure. This block sits directly upstream of the rotator and owns its `d_in`/`bit_amount` inputs, so the datapath can perform multi-step rotation sequences.

## Interface
- `DATA_W`, 8, operand width; fixed at 8 to match the rotator.
- `AMT_W`, 3, rotate-amount width.
- `CNT_W`, 4, repeat-count width; up to 15 steps per command.

- `clk`  in  1  single clock; all state updates on its rising edge.
- `rst`  in  1  asynchronous, active-high reset.
- `cmd_valid`  in  1  command present.
- `cmd_ready`  out  1  block can accept a command.
- `cmd_data`  in  DATA_W  initial operand.
- `cmd_amount`  in  AMT_W  bits rotated right per step.
- `cmd_count`  in  CNT_W  number of steps and results to emit.
- `out_valid`  out  1  `d_out` holds a result.
- `out_ready`  in  1  consumer accepts the result.
- `d_out`  out  DATA_W  current rotated value, registered.
- `out_last`  out  1  current result is the final one of the command.
- `busy`  out  1  command in progress (state RUN).

## Operation
- States: IDLE and RUN. Encoding: IDLE=0, RUN=1.
- `cmd_ready` = (state == IDLE), combinational from state. `busy` = (state == RUN).
- Rotator input mux:
  - IDLE: `d_in` = `cmd_data`, `bit_amount` = `cmd_amount`.
  - RUN: `d_in` = `d_out`, `bit_amount` = `amt_q`.
- IDLE, when `cmd_valid` is high:
  - Latch `amt_q` = `cmd_amount` and `remaining` = `cmd_count`.
  - If `cmd_count` != 0: `d_out` <= rot(`cmd_data`, `cmd_amount`), `out_valid` <= 1, go to RUN.
  - If `cmd_count` == 0: command consumed, no output, stay in IDLE.
- RUN, when `out_valid` & `out_ready`:
  - If `remaining` == 1: `out_valid` <= 0, go to IDLE; `d_out` keeps its last value.
  - Otherwise: `d_out` <= rot(`d_out`, `amt_q`), `remaining` <= `remaining` - 1, `out_valid` stays 1.
- RUN with `out_ready` low: `d_out`, `remaining` and `out_valid` hold unchanged.
- `out_last` = `out_valid` & (`remaining` == 1).
- Rotation arithmetic:
  - rot(x, k) = {x[k-1:0], x[7:k]}; rot(x, 0) = x.
  - `remaining` never underflows; it is only decremented when > 1.
- Commands cannot overlap: `cmd_ready` is 0 throughout RUN.

## Timing
- Reset values: state=IDLE, `d_out`=0x00, `out_valid`=0, `amt_q`=0, `remaining`=0. Consequently `cmd_ready`=1, `busy`=0, `out_last`=0.
- Reset acts immediately (asynchronously) even mid-command. The in-flight sequence is discarded with no further results; `cmd_ready` is 1 on the first edge after release.
- Latency: command accepted at edge N gives first result valid after edge N, i.e. in cycle N+1.
- Throughput: one result per cycle while `out_ready` stays high.
- Command-to-command gap:
  - After the final handshake at edge M, `cmd_ready` is 1 in cycle M+1.
  - The next command is accepted no earlier than edge M+1.
  - Minimum per command = count + 1 cycles.
- Zero-count command occupies one cycle and leaves `cmd_ready` asserted.
- Wrap-around: amount k applied 8/gcd(k,8) times returns the original operand; no special handling required.

## Structure
- Shared package `rotator_pkg`:
  - `DATA_W`, `AMT_W`, `CNT_W` constants.
  - State enum `rsc_state_t` {RSC_IDLE, RSC_RUN}.
- Single sub-module: the existing combinational `right_rotator`, instantiated once and fed by the input mux.
- Only registers: state, `d_out`, `out_valid`, `amt_q`, `remaining`.

## Test plan
- Reset mid-command: `cmd_data`=0x0F, `cmd_amount`=4, `cmd_count`=5; assert `rst` after 2 results. Required: `out_valid`=0 and `d_out`=0x00 immediately; `cmd_ready`=1 after release; no stale results emitted.
- Single step: `cmd_data`=0x81, `cmd_amount`=1, `cmd_count`=1, `out_ready`=1. Required: one cycle later `d_out`=0xC0, `out_valid`=1, `out_last`=1; next cycle `out_valid`=0, `cmd_ready`=1.
- Full wrap: `cmd_data`=0x01, `cmd_amount`=1, `cmd_count`=8. Required: results 0x80, 0x40, 0x20, 0x10, 0x08, 0x04, 0x02, 0x01 on consecutive cycles; `out_last` only on 0x01.
- Backpressure: `cmd_data`=0xB4, `cmd_amount`=3, `cmd_count`=2, `out_ready` low for 3 cycles after the first result. Required: `d_out`=0x96 stable while stalled; then 0xD2 with `out_last`=1.
- Zero amount / zero count:
  - `cmd_data`=0xA5, `cmd_amount`=0, `cmd_count`=3. Required: 0xA5 three times.
  - Then `cmd_count`=0. Required: no `out_valid`; `cmd_ready` stays 1.
- No overlap: hold `cmd_valid` high during RUN with new `cmd_data`=0xFF. Required: not accepted until IDLE; the current sequence is unaffected.
